// File: rtl/antialias_pkg.sv
// antialias_pkg: widths, state encoding and Q1.31 alias-reduction coefficients
package antialias_pkg;
  localparam int SAMPLE_W = 32;
  localparam int COEF_W = 32;
  localparam int N_SAMPLES = 576;
  localparam int N_BUTTERFLY = 248;
  localparam int N_PAIRS = 288;
  typedef enum logic [1:0] {LOAD, PROC, DONE} state_t;
  function automatic logic signed [COEF_W-1:0] q31(input real v);
    return 32'(v < 0.0 ? $rtoi(v * 2147483648.0 - 0.5) : $rtoi(v * 2147483648.0 + 0.5));
  endfunction
  function automatic logic signed [COEF_W-1:0] cs_q(input real c);
    return q31(1.0 / $sqrt(1.0 + c * c));
  endfunction
  function automatic logic signed [COEF_W-1:0] ca_q(input real c);
    return q31(c / $sqrt(1.0 + c * c));
  endfunction
  localparam logic signed [COEF_W-1:0] CS [0:7] = '{
    cs_q(-0.6), cs_q(-0.535), cs_q(-0.33), cs_q(-0.185),
    cs_q(-0.095), cs_q(-0.041), cs_q(-0.0142), cs_q(-0.0037)};
  localparam logic signed [COEF_W-1:0] CA [0:7] = '{
    ca_q(-0.6), ca_q(-0.535), ca_q(-0.33), ca_q(-0.185),
    ca_q(-0.095), ca_q(-0.041), ca_q(-0.0142), ca_q(-0.0037)};
  // t is the rounded sum already shifted right by 31; it fits iff its top three bits agree
  function automatic logic [SAMPLE_W-1:0] sat(input logic [33:0] t);
    return (t[33:31] == 3'b000 || t[33:31] == 3'b111) ? t[31:0] :
           t[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction
endpackage

// File: rtl/antialias_butterfly_dp.sv
// antialias_bfly_dp: one channel's butterfly multiply, round-half-up and saturate, with bypass
module antialias_bfly_dp
  import antialias_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] i_x,
  input  logic signed [SAMPLE_W-1:0] i_y,
  input  logic signed [COEF_W-1:0]   i_cs,
  input  logic signed [COEF_W-1:0]   i_ca,
  input  logic                       i_byp,
  output logic signed [SAMPLE_W-1:0] o_x,
  output logic signed [SAMPLE_W-1:0] o_y
);
  localparam logic signed [64:0] RND = 65'sh4000_0000;
  logic signed [63:0] r_xc, r_xa, r_yc, r_ya;
  logic signed [SAMPLE_W-1:0] r_x, r_y;
  logic r_byp;
  logic signed [64:0] w_sx, w_sy;
  logic [33:0] w_tx, w_ty;
  assign w_sx = 65'(r_xc) - 65'(r_ya) + RND;
  assign w_sy = 65'(r_yc) + 65'(r_xa) + RND;
  assign w_tx = 34'(w_sx >>> 31);
  assign w_ty = 34'(w_sy >>> 31);
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_xc, r_xa, r_yc, r_ya} <= '0;
      {r_x, r_y, r_byp} <= '0;
      {o_x, o_y} <= '0;
    end else begin
      r_xc <= 64'(i_x) * 64'(i_cs);
      r_xa <= 64'(i_x) * 64'(i_ca);
      r_yc <= 64'(i_y) * 64'(i_cs);
      r_ya <= 64'(i_y) * 64'(i_ca);
      r_x <= i_x;
      r_y <= i_y;
      r_byp <= i_byp;
      o_x <= r_byp ? r_x : sat(w_tx);
      o_y <= r_byp ? r_y : sat(w_ty);
    end
  end
endmodule

// File: rtl/antialias_butterfly.sv
// antialias_butterfly: granule buffer plus alias-reduction butterflies, emitted in reorder-stage order
module antialias_butterfly
  import antialias_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                new_frame_start,
  input  logic                ch1_short_in,
  input  logic                ch1_mixed_in,
  input  logic                ch2_short_in,
  input  logic                ch2_mixed_in,
  input  logic [SAMPLE_W-1:0] ch1_in,
  input  logic [SAMPLE_W-1:0] ch2_in,
  input  logic                valid_in,
  output logic [SAMPLE_W-1:0] ch1_x_out,
  output logic [SAMPLE_W-1:0] ch1_y_out,
  output logic [SAMPLE_W-1:0] ch2_x_out,
  output logic [SAMPLE_W-1:0] ch2_y_out,
  output logic [9:0]          x_pos_out,
  output logic [9:0]          y_pos_out,
  output logic                valid_out,
  output logic                overflow_out
);
  state_t r_state;
  logic [9:0] r_load_cnt;
  logic [8:0] r_k;
  logic r_ovf, r_s1, r_m1, r_s2, r_m2;
  logic [63:0] r_mem [0:N_SAMPLES-1];
  logic [63:0] r_ra, r_rb, r_ra2, r_rb2;
  logic [3:0] r_v;
  logic [3:0][9:0] r_xp, r_yp;
  logic [1:0] r_e1, r_e2;
  logic [1:0][2:0] r_ci;
  logic w_clr, w_proc, w_bf, w_en1, w_en2;
  logic [4:0] w_sb;
  logic [5:0] w_j, w_s;
  logic [9:0] w_base, w_xp, w_yp;
  assign w_clr = rst | new_frame_start;
  assign w_proc = r_state == PROC;
  assign w_bf = r_k < 9'(N_BUTTERFLY);
  assign w_en1 = w_bf && (r_m1 ? r_k < 9'd8 : !r_s1);
  assign w_en2 = w_bf && (r_m2 ? r_k < 9'd8 : !r_s2);
  assign w_sb = r_k[7:3] + 5'd1;
  assign w_j = 6'(r_k - 9'(N_BUTTERFLY));
  assign w_s = w_j - 6'd4;
  assign w_base = 10'(w_sb) * 10'd18;
  // pass-through pairs: low edge, the two gap samples between subbands, high edge
  always_comb begin
    w_xp = w_bf ? w_base - 10'd1 - 10'(r_k[2:0]) :
           w_j < 6'd5 ? 10'({w_j, 1'b0}) :
           w_j < 6'd35 ? 10'(w_s) * 10'd18 + 10'd8 :
           10'd566 + 10'({w_j - 6'd35, 1'b0});
    w_yp = w_bf ? w_base + 10'(r_k[2:0]) : w_xp + 10'd1;
  end
  always_ff @(posedge clk) begin
    if (!w_clr && r_state == LOAD && valid_in) r_mem[r_load_cnt] <= {ch1_in, ch2_in};
    r_ra <= r_mem[w_xp];
    r_rb <= r_mem[w_yp];
    r_ra2 <= r_ra;
    r_rb2 <= r_rb;
  end
  always_ff @(posedge clk) begin
    if (rst) {r_s1, r_m1, r_s2, r_m2} <= '0;
    else if (new_frame_start) {r_s1, r_m1, r_s2, r_m2} <= {ch1_short_in, ch1_mixed_in, ch2_short_in, ch2_mixed_in};
  end
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= LOAD;
      r_load_cnt <= '0;
      r_k <= '0;
      r_ovf <= 1'b0;
      r_v <= '0;
      r_xp <= '0;
      r_yp <= '0;
      r_e1 <= '0;
      r_e2 <= '0;
      r_ci <= '0;
    end else begin
      r_v <= {r_v[2:0], w_proc};
      r_xp <= {r_xp[2:0], w_xp};
      r_yp <= {r_yp[2:0], w_yp};
      r_e1 <= {r_e1[0], w_en1};
      r_e2 <= {r_e2[0], w_en2};
      r_ci <= {r_ci[0], r_k[2:0]};
      if (valid_in && r_state != LOAD) r_ovf <= 1'b1;
      if (r_state == LOAD && valid_in) begin
        r_load_cnt <= r_load_cnt + 10'd1;
        if (r_load_cnt == 10'(N_SAMPLES - 1)) r_state <= PROC;
      end
      if (w_proc) begin
        r_k <= r_k + 9'd1;
        if (r_k == 9'(N_PAIRS - 1)) r_state <= DONE;
      end
    end
  end
  antialias_bfly_dp u_dp1 (
    .clk(clk), .rst(w_clr), .i_x(r_ra2[63:32]), .i_y(r_rb2[63:32]),
    .i_cs(CS[r_ci[1]]), .i_ca(CA[r_ci[1]]), .i_byp(!r_e1[1]),
    .o_x(ch1_x_out), .o_y(ch1_y_out));
  antialias_bfly_dp u_dp2 (
    .clk(clk), .rst(w_clr), .i_x(r_ra2[31:0]), .i_y(r_rb2[31:0]),
    .i_cs(CS[r_ci[1]]), .i_ca(CA[r_ci[1]]), .i_byp(!r_e2[1]),
    .o_x(ch2_x_out), .o_y(ch2_y_out));
  assign x_pos_out = r_xp[3];
  assign y_pos_out = r_yp[3];
  assign valid_out = r_v[3];
  assign overflow_out = r_ovf;
endmodule

// File: tb/tb_antialias_butterfly.sv
// tb_antialias_butterfly: directed granules against a golden butterfly model and hand values
module tb_antialias_butterfly;
  logic clk = 1'b0;
  logic rst, nfs, s1, m1, s2, m2, valid_in, vo, ovf;
  logic [31:0] ch1_in, ch2_in, c1x, c1y, c2x, c2y;
  logic [9:0] xp, yp;
  int n_tests = 0, n_fail = 0;
  logic [31:0] g1 [576];
  logic [31:0] g2 [576];
  int epx [288];
  int epy [288];
  logic [9:0] obx [288];
  logic [9:0] oby [288];
  logic [31:0] ox1 [288];
  logic [31:0] oy1 [288];
  logic [31:0] ox2 [288];
  logic [31:0] oy2 [288];
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  always #5 clk = ~clk;

  antialias_butterfly dut (
    .clk(clk), .rst(rst), .new_frame_start(nfs),
    .ch1_short_in(s1), .ch1_mixed_in(m1), .ch2_short_in(s2), .ch2_mixed_in(m2),
    .ch1_in(ch1_in), .ch2_in(ch2_in), .valid_in(valid_in),
    .ch1_x_out(c1x), .ch1_y_out(c1y), .ch2_x_out(c2x), .ch2_y_out(c2y),
    .x_pos_out(xp), .y_pos_out(yp), .valid_out(vo), .overflow_out(ovf));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real cval(input int i);
    case (i)
      0: return -0.6;
      1: return -0.535;
      2: return -0.33;
      3: return -0.185;
      4: return -0.095;
      5: return -0.041;
      6: return -0.0142;
      default: return -0.0037;
    endcase
  endfunction
  function automatic longint q31(input real v);
    return v < 0.0 ? longint'($rtoi(v * 2147483648.0 - 0.5)) : longint'($rtoi(v * 2147483648.0 + 0.5));
  endfunction
  function automatic longint bcs(input int i);
    real c = cval(i);
    return q31(1.0 / $sqrt(1.0 + c * c));
  endfunction
  function automatic longint bca(input int i);
    real c = cval(i);
    return q31(c / $sqrt(1.0 + c * c));
  endfunction
  function automatic longint sat31(input longint s);
    return s > MAXV ? MAXV : s < MINV ? MINV : s;
  endfunction
  function automatic logic [63:0] bfly(input logic [31:0] x, input logic [31:0] y, input int i);
    longint xs = longint'($signed(x));
    longint ys = longint'($signed(y));
    longint nx = sat31((xs * bcs(i) - ys * bca(i) + 64'sd1073741824) >>> 31);
    longint ny = sat31((ys * bcs(i) + xs * bca(i) + 64'sd1073741824) >>> 31);
    return {nx[31:0], ny[31:0]};
  endfunction
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input int k,
                                        input logic sh, input logic mx);
    bit en = k < 248 && (mx ? k < 8 : !sh);
    return en ? bfly(x, y, k % 8) : {x, y};
  endfunction

  task automatic build_pos();
    bit used [576];
    int u [80];
    int nu = 0;
    for (int k = 0; k < 248; k++) begin
      epx[k] = 18 * (1 + k / 8) - 1 - k % 8;
      epy[k] = 18 * (1 + k / 8) + k % 8;
      used[epx[k]] = 1'b1;
      used[epy[k]] = 1'b1;
    end
    for (int n = 0; n < 576; n++)
      if (!used[n]) begin
        if (nu < 80) u[nu] = n;
        nu++;
      end
    for (int j = 0; j < 40; j++) begin
      epx[248 + j] = u[2 * j];
      epy[248 + j] = u[2 * j + 1];
    end
  endtask

  task automatic restart(input logic fs1, input logic fm1, input logic fs2, input logic fm2);
    @(negedge clk);
    nfs = 1'b1;
    {s1, m1, s2, m2} = {fs1, fm1, fs2, fm2};
    valid_in = 1'b1;
    ch1_in = 32'hBAD0_0001;
    ch2_in = 32'hBAD0_0002;
  endtask

  task automatic load();
    for (int n = 0; n < 576; n++) begin
      @(negedge clk);
      nfs = 1'b0;
      valid_in = 1'b1;
      ch1_in = g1[n];
      ch2_in = g2[n];
    end
  endtask

  task automatic collect(input logic fs1, input logic fm1, input logic fs2, input logic fm2, input bit inj);
    int nb = 0;
    int first = -1;
    int once = 0;
    int seen [576];
    bit gap = 0, prev = 0;
    for (int c = 1; c <= 320; c++) begin
      @(negedge clk);
      valid_in = inj && ((c >= 10 && c < 13) || c == 310);
      ch1_in = 32'h1234_5678;
      ch2_in = 32'h8765_4321;
      if (vo) begin
        if (first < 0) first = c;
        else if (!prev) gap = 1'b1;
        if (nb < 288) begin
          obx[nb] = xp; oby[nb] = yp;
          ox1[nb] = c1x; oy1[nb] = c1y; ox2[nb] = c2x; oy2[nb] = c2y;
        end
        nb++;
      end
      prev = vo;
    end
    valid_in = 1'b0;
    chk("beats", 64'(nb), 64'd288);
    chk("latency", 64'(first - 1), 64'd4);
    chk("gap", 64'(gap), 64'd0);
    chk("overflow", 64'(ovf), 64'(inj));
    for (int k = 0; k < nb && k < 288; k++) begin
      chk($sformatf("pos%0d", k), {44'd0, obx[k], oby[k]}, {44'd0, 10'(epx[k]), 10'(epy[k])});
      chk($sformatf("ch1_%0d", k), {ox1[k], oy1[k]}, model(g1[epx[k]], g1[epy[k]], k, fs1, fm1));
      chk($sformatf("ch2_%0d", k), {ox2[k], oy2[k]}, model(g2[epx[k]], g2[epy[k]], k, fs2, fm2));
      seen[obx[k]]++;
      seen[oby[k]]++;
    end
    for (int n = 0; n < 576; n++) if (seen[n] == 1) once++;
    chk("cover", 64'(once), 64'd576);
  endtask

  task automatic run(input logic fs1, input logic fm1, input logic fs2, input logic fm2, input bit inj);
    restart(fs1, fm1, fs2, fm2);
    load();
    collect(fs1, fm1, fs2, fm2, inj);
  endtask

  initial begin
    rst = 1'b1; nfs = 1'b0; {s1, m1, s2, m2} = '0; valid_in = 1'b0; ch1_in = '0; ch2_in = '0;
    build_pos();
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(vo), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_xpos", 64'(xp), 64'd0);
    chk("rst_ch1x", 64'(c1x), 64'd0);
    chk("rst_ch2y", 64'(c2y), 64'd0);
    rst = 1'b0;

    for (int n = 0; n < 576; n++) begin g1[n] = 32'(n); g2[n] = 32'(-n); end
    run(1, 0, 1, 0, 0);
    chk("ramp_x0", {32'd0, ox1[0]}, 64'd17);
    chk("ramp_x0_ch2", {32'd0, ox2[0]}, 64'hFFFF_FFEF);
    chk("ramp_pass0", {ox1[248], oy1[248]}, {32'd0, 32'd1});

    for (int n = 0; n < 576; n++) begin g1[n] = '0; g2[n] = '0; end
    g1[17] = 32'h4000_0000;
    run(0, 0, 0, 0, 0);
    chk("imp_x", {32'd0, ox1[0]}, {32'd0, 32'((bcs(0) + 1) >>> 1)});
    chk("imp_y", {32'd0, oy1[0]}, {32'd0, 32'((bca(0) + 1) >>> 1)});

    for (int n = 0; n < 576; n++) begin g1[n] = $urandom; g2[n] = $urandom; end
    run(0, 0, 1, 1, 0);

    for (int n = 0; n < 576; n++) begin g1[n] = '0; g2[n] = '0; end
    g1[17] = 32'h7FFF_FFFF; g1[18] = 32'h8000_0000; g1[16] = 32'h7FFF_FFFF; g1[19] = 32'h7FFF_FFFF;
    run(0, 0, 0, 0, 1);
    chk("sat_y0", {32'd0, oy1[0]}, 64'h8000_0000);
    chk("sat_x1", {32'd0, ox1[1]}, 64'h7FFF_FFFF);

    for (int n = 0; n < 576; n++) begin g1[n] = $urandom; g2[n] = $urandom; end
    restart(0, 0, 0, 0);
    load();
    for (int c = 1; c <= 101; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
    chk("abort_pre", 64'(vo), 64'd1);
    nfs = 1'b1;
    {s1, m1, s2, m2} = 4'b0010;
    valid_in = 1'b1;
    ch1_in = 32'hBAD0_0003;
    @(negedge clk);
    chk("abort_vo", 64'(vo), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    nfs = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    chk("abort_vo2", 64'(vo), 64'd0);
    for (int n = 0; n < 576; n++) begin g1[n] = $urandom; g2[n] = $urandom; end
    load();
    collect(0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
